reg_bank_arb: RTL and testbench

REG_BANK_ARB -- requirements
Module: reg_bank_arb

---
 rtl/reg_bank_pkg.sv | 31 +++
 rtl/reg_bank_arb_rr_arbiter.sv | 56 +++++
 rtl/reg_bank_arb.sv | 106 ++++++++++
 tb/tb_reg_bank_arb.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants, sizing helper and response record for the arbitrated register bank.
package reg_bank_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_CH    = 2;

  // Widest supported data word and channel index. The response record is
  // sized for these so one typedef serves every parameterisation.
  localparam int MAX_WIDTH = 64;
  localparam int MAX_CW    = 3;

  // Ceiling log2. Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Registered response fields. Narrower configurations use the low bits.
  typedef struct packed {
    logic [MAX_CW-1:0]    ch;
    logic                 we;
    logic                 err;
    logic [MAX_WIDTH-1:0] data;
  } rsp_t;

endpackage

// File: rtl/reg_bank_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner whenever a grant is taken.
module rr_arbiter
  import reg_bank_pkg::*;
#(
  parameter int  CH = DEF_CH,
  localparam int CW = (clog2(CH) < 1) ? 1 : clog2(CH)
) (
  input  logic          clk,
  input  logic          rst_n,    // active-high asynchronous reset
  input  logic [CH-1:0] req,
  input  logic          advance,  // a grant was consumed this cycle
  output logic [CH-1:0] gnt,
  output logic [CW-1:0] gnt_idx
);

  logic [CW-1:0] ptr_q;
  logic [CW-1:0] ptr_d;

  // Search CH positions starting at the pointer; nothing is granted in reset.
  always_comb begin
    logic found;
    int   idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= CH) idx = idx - CH;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = CW'(idx);
        end
      end
    end
  end

  // Next pointer is one past the winner, wrapping at CH; holds otherwise.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (int'(gnt_idx) >= CH - 1) ptr_d = '0;
      else                         ptr_d = CW'(int'(gnt_idx) + 1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_bank_arb.sv
// Register bank shared by CH requesters through a round-robin arbiter.
// One request is accepted per cycle and answered exactly one cycle later.
//
// Handshake: channel i transfers on a rising edge where req_valid[i] and
// req_ready[i] are both 1. req_ready is combinational, at most one bit is
// set, and a requester may change its request at any time before it is
// granted. Responses have no back-pressure: rsp_valid is a one-cycle strobe.
module reg_bank_arb
  import reg_bank_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DEPTH = DEF_DEPTH,
  parameter int  CH    = DEF_CH,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = (clog2(CH) < 1) ? 1 : clog2(CH)
) (
  input  logic                clk,
  input  logic                rst_n,      // active-high asynchronous reset
  input  logic [CH-1:0]       req_valid,
  output logic [CH-1:0]       req_ready,
  input  logic [CH-1:0]       req_we,
  input  logic [CH*AW-1:0]    req_addr,
  input  logic [CH*WIDTH-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [CW-1:0]       rsp_ch,
  output logic                rsp_we,
  output logic [WIDTH-1:0]    rsp_data,
  output logic                rsp_err
);

  logic [CH-1:0]    gnt;
  logic [CW-1:0]    gnt_idx;
  logic             xfer;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             in_range;

  logic [WIDTH-1:0] regs_q [DEPTH];
  rsp_t             rsp_q;
  rsp_t             rsp_d;
  logic             rsp_valid_q;
  logic             unused_rsp;

  rr_arbiter #(.CH(CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The arbiter only grants valid channels, so any grant is a transfer.
  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel_we    = req_we[gnt_idx];
  assign sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
  assign sel_wdata = req_wdata[int'(gnt_idx)*WIDTH +: WIDTH];
  assign in_range  = int'(sel_addr) < DEPTH;

  // Build the response for the granted request; fields hold when idle.
  // Reads return the entry as it stood before this edge's write.
  always_comb begin
    rsp_d = rsp_q;
    if (xfer) begin
      rsp_d     = '0;
      rsp_d.ch  = MAX_CW'(gnt_idx);
      rsp_d.we  = sel_we;
      rsp_d.err = !in_range;
      if (in_range) begin
        rsp_d.data = MAX_WIDTH'(sel_we ? sel_wdata : regs_q[sel_addr]);
      end
    end
  end

  // Flop-array storage so every entry clears on reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (xfer && sel_we && in_range) begin
      regs_q[sel_addr] <= sel_wdata;
    end
  end

  // Response registers; reset drops any response still in flight.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_q       <= rsp_d;
      rsp_valid_q <= xfer;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_ch    = rsp_q.ch[CW-1:0];
  assign rsp_we    = rsp_q.we;
  assign rsp_err   = rsp_q.err;
  assign rsp_data  = rsp_q.data[WIDTH-1:0];

  // Upper record bits beyond this configuration's widths stay zero.
  assign unused_rsp = ^rsp_q;

endmodule

// File: tb/tb_reg_bank_arb.sv
// Directed bench for reg_bank_arb with CH=3 (non-power-of-two wrap),
// DEPTH=10 (out-of-range addresses exist) and WIDTH=8.
module tb_reg_bank_arb;

  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int CH    = 3;
  localparam int AW    = 4;
  localparam int CW    = 2;
  localparam int W     = CW + 2 + WIDTH;   // {ch, we, err, data}

  logic                clk;
  logic                rst_n;
  logic [CH-1:0]       req_valid;
  logic [CH-1:0]       req_ready;
  logic [CH-1:0]       req_we;
  logic [CH*AW-1:0]    req_addr;
  logic [CH*WIDTH-1:0] req_wdata;
  logic                rsp_valid;
  logic [CW-1:0]       rsp_ch;
  logic                rsp_we;
  logic [WIDTH-1:0]    rsp_data;
  logic                rsp_err;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int           n_pass;
  int           n_total;

  reg_bank_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CH(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ch    (rsp_ch),
    .rsp_we    (rsp_we),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Driver tasks
  task automatic clr_req();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int ch, input logic we, input logic [AW-1:0] addr,
                         input logic [WIDTH-1:0] wd);
    req_valid[ch]               = 1'b1;
    req_we[ch]                  = we;
    req_addr[ch*AW +: AW]       = addr;
    req_wdata[ch*WIDTH +: WIDTH] = wd;
  endtask

  task automatic push(input logic [CW-1:0] ch, input logic we, input logic err,
                      input logic [WIDTH-1:0] data);
    exp_q.push_back({ch, we, err, data});
  endtask

  // Called at posedge+1: check the grant, then advance to the next posedge+1.
  task automatic step(input logic [CH-1:0] exp_rdy, input string name);
    #2;
    check(name, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: sample outputs on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_fields", 32'({rsp_ch, rsp_we, rsp_err, rsp_data}), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      last_exp = '0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: got ch=%0d we=%0b err=%0b data=0x%0h, required no response",
                 rsp_ch, rsp_we, rsp_err, rsp_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("rsp", 32'({rsp_ch, rsp_we, rsp_err, rsp_data}), 32'(e));
        last_exp = e;
      end
    end else begin
      check("rsp_hold", 32'({rsp_ch, rsp_we, rsp_err, rsp_data}), 32'(last_exp));
    end
  end

  initial begin
    n_pass   = 0;
    n_total  = 0;
    last_exp = '0;
    rst_n    = 1'b1;
    clr_req();
    @(posedge clk);
    #1;

    // Requests held during reset must never be granted.
    set_req(0, 1'b0, 4'd1, 8'h00);
    set_req(1, 1'b1, 4'd1, 8'hEE);
    repeat (3) step(3'b000, "ready_in_reset");

    // Release; first transfer at the next edge. Read addr 5 -> 0.
    rst_n = 1'b0;
    clr_req();
    set_req(0, 1'b0, 4'd5, 8'h00);
    push(2'd0, 1'b0, 1'b0, 8'h00);
    step(3'b001, "rdy_read5");

    // ch1 writes 0xA5 to addr 3, then ch0 reads it back (P=2 wraps to 0).
    clr_req();
    set_req(1, 1'b1, 4'd3, 8'hA5);
    push(2'd1, 1'b1, 1'b0, 8'hA5);
    step(3'b010, "rdy_wr3");
    clr_req();
    set_req(0, 1'b0, 4'd3, 8'h00);
    push(2'd0, 1'b0, 1'b0, 8'hA5);
    step(3'b001, "rdy_rd3");

    // Idle cycle: no grant, response fields hold.
    clr_req();
    step(3'b000, "rdy_idle");

    // P=1: ch2 writes 0x3C to addr 9, leaving P=0.
    set_req(2, 1'b1, 4'd9, 8'h3C);
    push(2'd2, 1'b1, 1'b0, 8'h3C);
    step(3'b100, "rdy_wr9");

    // ch0 and ch1 both held for 4 cycles from P=0 -> grants 0,1,0,1.
    clr_req();
    set_req(0, 1'b0, 4'd9, 8'h00);
    set_req(1, 1'b1, 4'd1, 8'h11);
    push(2'd0, 1'b0, 1'b0, 8'h3C);
    step(3'b001, "rr_a");
    push(2'd1, 1'b1, 1'b0, 8'h11);
    step(3'b010, "rr_b");
    set_req(1, 1'b1, 4'd1, 8'h22);
    push(2'd0, 1'b0, 1'b0, 8'h3C);
    step(3'b001, "rr_c");
    push(2'd1, 1'b1, 1'b0, 8'h22);
    step(3'b010, "rr_d");

    // P=2: out-of-range read and write, storage untouched.
    clr_req();
    set_req(2, 1'b0, 4'd12, 8'h00);
    push(2'd2, 1'b0, 1'b1, 8'h00);
    step(3'b100, "rdy_oor_rd");
    clr_req();
    set_req(0, 1'b1, 4'd15, 8'hFF);
    push(2'd0, 1'b1, 1'b1, 8'h00);
    step(3'b001, "rdy_oor_wr");
    clr_req();
    set_req(1, 1'b0, 4'd9, 8'h00);
    push(2'd1, 1'b0, 1'b0, 8'h3C);
    step(3'b010, "rdy_rd9");
    clr_req();
    set_req(1, 1'b0, 4'd1, 8'h00);
    push(2'd1, 1'b0, 1'b0, 8'h22);
    step(3'b010, "rdy_rd1");

    // P=2 with ch0 and ch2 valid: ch2 writes addr 0, then ch0 reads it.
    clr_req();
    set_req(2, 1'b1, 4'd0, 8'h77);
    set_req(0, 1'b0, 4'd0, 8'h00);
    push(2'd2, 1'b1, 1'b0, 8'h77);
    step(3'b100, "wrap_wr0");
    clr_req();
    set_req(0, 1'b0, 4'd0, 8'h00);
    push(2'd0, 1'b0, 1'b0, 8'h77);
    step(3'b001, "wrap_rd0");

    // P=1: ch0 writes addr 2, reset lands before its response is seen.
    clr_req();
    set_req(0, 1'b1, 4'd2, 8'h5A);
    step(3'b001, "rdy_wr2");
    rst_n = 1'b1;
    clr_req();
    set_req(1, 1'b0, 4'd2, 8'h00);
    repeat (2) step(3'b000, "ready_in_reset2");

    // After release P=0: addr 2 and addr 0 both read back as zero.
    rst_n = 1'b0;
    push(2'd1, 1'b0, 1'b0, 8'h00);
    step(3'b010, "rdy_post_rd2");
    clr_req();
    set_req(2, 1'b0, 4'd0, 8'h00);
    push(2'd2, 1'b0, 1'b0, 8'h00);
    step(3'b100, "rdy_post_rd0");

    clr_req();
    repeat (3) step(3'b000, "rdy_idle_end");
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
